// File: rtl/alu_result_checker.sv
// Response checker for the 4-op logic unit: queues golden results and scores returned ones.
// Optional build macro CHECK_STOP_ON_FAIL_EN: freeze all checking after the first failure.
module alu_result_checker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stim_valid,
  output logic                       stim_ready,
  input  logic [WIDTH-1:0]           stim_a,
  input  logic [WIDTH-1:0]           stim_b,
  input  logic [1:0]                 stim_sel,
  input  logic                       res_valid,
  input  logic [WIDTH-1:0]           res_data,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic                       mismatch,
  output logic                       unexpected,
  output logic                       err_sticky,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] golden;
  logic             running, empty, full;
  logic             push, pop, miss_ev, unexp_ev;

  // Handshakes: a stimulus transfers on stim_valid && stim_ready; a result is
  // consumed whenever res_valid is high (no back-pressure on the result side).
  always_comb begin
    golden = '0;
    case (stim_sel)
      2'b00:   golden = stim_a & stim_b;
      2'b01:   golden = stim_a | stim_b;
      2'b10:   golden = stim_a ^ stim_b;
      default: golden = ~(stim_a & stim_b);
    endcase
  end

  // Everything below is judged on registered state, so res_valid never reaches stim_ready.
  assign running    = (state == RUN);
  assign empty      = (pending == '0);
  assign full       = (pending == FULL_LVL);
  assign stim_ready = running && !full;
  assign push       = stim_valid && stim_ready;
  assign pop        = running && res_valid && !empty;
  assign unexp_ev   = running && res_valid && empty;
  assign miss_ev    = pop && (res_data != mem[rd_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
`ifdef CHECK_STOP_ON_FAIL_EN
    if (state == RUN && (miss_ev || unexp_ev)) state_next = HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= golden;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      mismatch   <= 1'b0;
      unexpected <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      mismatch   <= miss_ev;
      unexpected <= unexp_ev;
      if (miss_ev || unexp_ev) err_sticky <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
      // Counters stick at all-ones rather than wrapping.
      if (pop && !miss_ev && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      if (miss_ev && fail_cnt != '1)         fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed vector table, saturation sequence,
// randomized traffic against a queue-based reference model, and async reset.
module tb_alu_result_checker;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_MAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             stim_valid, stim_ready, res_valid;
  logic [WIDTH-1:0] stim_a, stim_b, res_data;
  logic [1:0]       stim_sel;
  logic [7:0]       pass_cnt, fail_cnt;
  logic             mismatch, unexpected, err_sticky;
  logic [2:0]       pending;

  logic             s_sv, s_ready, s_rv;
  logic [WIDTH-1:0] s_a, s_b, s_rd;
  logic [1:0]       s_sel;
  logic [1:0]       s_pass, s_fail;
  logic             s_mis, s_une, s_st;
  logic [2:0]       s_pend;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] exp_q[$];
  int m_pass, m_fail;
  bit m_st, m_halt;

  typedef struct {
    bit              rst;
    bit              sv;
    logic [WIDTH-1:0] a, b;
    logic [1:0]      sel;
    bit              rv;
    logic [WIDTH-1:0] rd;
    bit              e_ready;
    int              e_pass, e_fail, e_pend;
    bit              e_mis, e_une, e_st;
  } vec_t;

  vec_t vecs[24];

  alu_result_checker dut (
    .clk(clk), .rst_n(rst_n),
    .stim_valid(stim_valid), .stim_ready(stim_ready),
    .stim_a(stim_a), .stim_b(stim_b), .stim_sel(stim_sel),
    .res_valid(res_valid), .res_data(res_data),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .mismatch(mismatch), .unexpected(unexpected),
    .err_sticky(err_sticky), .pending(pending)
  );

  alu_result_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .stim_valid(s_sv), .stim_ready(s_ready),
    .stim_a(s_a), .stim_b(s_b), .stim_sel(s_sel),
    .res_valid(s_rv), .res_data(s_rd),
    .pass_cnt(s_pass), .fail_cnt(s_fail),
    .mismatch(s_mis), .unexpected(s_une),
    .err_sticky(s_st), .pending(s_pend)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stim_valid = 0; stim_a = '0; stim_b = '0; stim_sel = '0;
    res_valid = 0; res_data = '0;
    s_sv = 0; s_a = '0; s_b = '0; s_sel = '0; s_rv = 0; s_rd = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    check("rst pass_cnt", pass_cnt, 0);
    check("rst fail_cnt", fail_cnt, 0);
    check("rst pending", pending, 0);
    check("rst err_sticky", err_sticky, 0);
    check("rst mismatch", mismatch, 0);
    check("rst unexpected", unexpected, 0);
    rst_n = 1;
    check("rst stim_ready", stim_ready, 1);
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_st = 0; m_halt = 0;
  endtask

  // Golden result straight from the operation table.
  function automatic logic [WIDTH-1:0] ref_op(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                              logic [1:0] sel);
    case (sel)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // ---------------- driver + model step ----------------
  task automatic step(input bit sv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] sel, input bit rv, input logic [WIDTH-1:0] rd);
    bit m_ready, e_mis, e_une;
    logic [WIDTH-1:0] e;
    m_ready = !m_halt && (exp_q.size() != DEPTH);
    check("stim_ready", stim_ready, m_ready);
    stim_valid = sv; stim_a = a; stim_b = b; stim_sel = sel;
    res_valid = rv; res_data = rd;
    e_mis = 0; e_une = 0;
    if (!m_halt && rv) begin
      if (exp_q.size() == 0) e_une = 1;
      else begin
        e = exp_q.pop_front();
        if (e == rd) m_pass = (m_pass < CNT_MAX) ? m_pass + 1 : CNT_MAX;
        else begin
          m_fail = (m_fail < CNT_MAX) ? m_fail + 1 : CNT_MAX;
          e_mis = 1;
        end
      end
    end
    if (sv && m_ready) exp_q.push_back(ref_op(a, b, sel));
    if (e_mis || e_une) m_st = 1;
`ifdef CHECK_STOP_ON_FAIL_EN
    if (e_mis || e_une) m_halt = 1;
`endif
    @(posedge clk); #1;
    stim_valid = 0; res_valid = 0;
    check("pass_cnt", pass_cnt, m_pass);
    check("fail_cnt", fail_cnt, m_fail);
    check("pending", pending, exp_q.size());
    check("mismatch", mismatch, e_mis);
    check("unexpected", unexpected, e_une);
    check("err_sticky", err_sticky, m_st);
  endtask

  function automatic vec_t mk(bit rst, bit sv, int a, int b, int sel, bit rv, int rd,
                              bit rdy, int p, int f, int pe, bit m, bit u, bit st);
    vec_t v;
    v.rst = rst; v.sv = sv; v.a = WIDTH'(a); v.b = WIDTH'(b); v.sel = 2'(sel);
    v.rv = rv; v.rd = WIDTH'(rd);
    v.e_ready = rdy; v.e_pass = p; v.e_fail = f; v.e_pend = pe;
    v.e_mis = m; v.e_une = u; v.e_st = st;
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] rd;
    bit sv, rv;
    idle_inputs();

    vecs[0]  = mk(1, 1, 9, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 9, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 9, 1, 1, 0, 0,  1, 0, 0, 2, 0, 0, 0);
    vecs[4]  = mk(0, 1, 9, 1, 2, 0, 0,  1, 0, 0, 3, 0, 0, 0);
    vecs[5]  = mk(0, 1, 9, 1, 3, 0, 0,  1, 0, 0, 4, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 3, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 9,  1, 2, 0, 2, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0,  1, 2, 1, 1, 1, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 14, 1, 3, 1, 0, 0, 0, 1);
    vecs[10] = mk(1, 1, 3, 5, 2, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 3, 5, 0, 0, 0,  1, 0, 0, 2, 0, 0, 0);
    vecs[12] = mk(0, 1, 3, 5, 1, 0, 0,  1, 0, 0, 3, 0, 0, 0);
    vecs[13] = mk(0, 1, 3, 5, 3, 0, 0,  1, 0, 0, 4, 0, 0, 0);
    vecs[14] = mk(0, 1, 15, 15, 0, 1, 6, 0, 1, 0, 3, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 1,  1, 2, 0, 2, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 7,  1, 3, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 14, 1, 4, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 1, 15, 1, 4, 0, 0, 0, 1, 1);
    vecs[19] = mk(1, 1, 12, 10, 2, 1, 6, 1, 0, 0, 1, 0, 1, 1);
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 6,  1, 1, 0, 0, 0, 0, 1);
    vecs[21] = mk(0, 1, 12, 10, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    vecs[22] = mk(0, 1, 12, 10, 0, 1, 14, 1, 2, 0, 1, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 8,  1, 3, 0, 0, 0, 0, 1);

`ifndef CHECK_STOP_ON_FAIL_EN
    // Directed table: one clock per row, outputs checked after the edge.
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].rst) do_reset();
      check($sformatf("row%0d stim_ready", i), stim_ready, vecs[i].e_ready);
      stim_valid = vecs[i].sv; stim_a = vecs[i].a; stim_b = vecs[i].b;
      stim_sel = vecs[i].sel; res_valid = vecs[i].rv; res_data = vecs[i].rd;
      @(posedge clk); #1;
      stim_valid = 0; res_valid = 0;
      check($sformatf("row%0d pass_cnt", i), pass_cnt, vecs[i].e_pass);
      check($sformatf("row%0d fail_cnt", i), fail_cnt, vecs[i].e_fail);
      check($sformatf("row%0d pending", i), pending, vecs[i].e_pend);
      check($sformatf("row%0d mismatch", i), mismatch, vecs[i].e_mis);
      check($sformatf("row%0d unexpected", i), unexpected, vecs[i].e_une);
      check($sformatf("row%0d err_sticky", i), err_sticky, vecs[i].e_st);
    end
`else
    // Stop-on-fail: mismatch halts, later traffic is ignored.
    do_reset();
    step(1, 4'd9, 4'd1, 2'd0, 0, 4'd0);
    step(0, 4'd0, 4'd0, 2'd0, 1, 4'd0);
    step(1, 4'd9, 4'd1, 2'd0, 1, 4'd1);
    step(0, 4'd0, 4'd0, 2'd0, 1, 4'd5);
    check("halt fail_cnt", fail_cnt, 1);
    check("halt pass_cnt", pass_cnt, 0);
    check("halt stim_ready", stim_ready, 0);
`endif

    // Saturation on the 2-bit-counter instance.
    do_reset();
    s_sv = 1; s_a = 4'd9; s_b = 4'd1; s_sel = 2'd0;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      s_sv = 1; s_rv = 1; s_rd = 4'd1;
      @(posedge clk); #1;
      check($sformatf("sat pass_cnt k%0d", k), s_pass, (k < 3) ? k : 3);
      check($sformatf("sat pending k%0d", k), s_pend, 1);
    end
    s_sv = 0; s_rv = 1; s_rd = 4'd1;
    @(posedge clk); #1;
    s_rv = 0;
    check("sat final pass_cnt", s_pass, 3);
    check("sat fail_cnt", s_fail, 0);
    check("sat pending", s_pend, 0);
    check("sat err_sticky", s_st, 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sv = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 45);
      if (exp_q.size() != 0 && $urandom_range(0, 7) != 0) rd = exp_q[0];
      else rd = WIDTH'($urandom_range(0, 15));
      step(sv, WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), rv, rd);
    end

    // Asynchronous reset between clock edges.
    step(1, 4'd6, 4'd3, 2'd1, 0, 4'd0);
    #3;
    rst_n = 0;
    #1;
    check("async pass_cnt", pass_cnt, 0);
    check("async fail_cnt", fail_cnt, 0);
    check("async pending", pending, 0);
    check("async err_sticky", err_sticky, 0);
    check("async stim_ready", stim_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("post-reset pending", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Self-checking response end for the 4-bit logic-unit stimulus path (AND/OR/XOR/NAND behind the 2-bit operation selector).
- Accepts stimulus vectors (a, b, selector) as issued and queues the golden result in an internal FIFO.
- Later pops each expected value against the unit's returned result and keeps pass/fail statistics.
- Sits beside the stimulus generator; the generator drives, this block judges.

Parameters:
- WIDTH, 4, operand/result width in bits.
- DEPTH, 4, expected-result FIFO depth; power of two, >= 2.
- CNT_W, 8, width of the pass/fail counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stim_valid  input  1  stimulus vector present.
- stim_ready  output  1  checker can accept stimulus.
- stim_a  input  WIDTH  operand a.
- stim_b  input  WIDTH  operand b.
- stim_sel  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- res_valid  input  1  returned result present; always accepted.
- res_data  input  WIDTH  returned result.
- pass_cnt  output  CNT_W  matching results, saturating.
- fail_cnt  output  CNT_W  mismatching results, saturating.
- mismatch  output  1  one-cycle pulse on a compare failure.
- unexpected  output  1  one-cycle pulse when res_valid arrives with FIFO empty.
- err_sticky  output  1  set on any mismatch or unexpected; cleared only by reset.
- pending  output  clog2(DEPTH)+1  number of expected results queued.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers = 0; pending = 0; counters = 0; mismatch = 0; unexpected = 0; err_sticky = 0. stim_ready = 1 immediately after reset release.
- Golden model: exp = sel 00: a&b; 01: a|b; 10: a^b; 11: ~(a&b). Result is WIDTH bits, no carry.
- Push: on stim_valid && stim_ready, exp is written at wr_ptr and wr_ptr increments. Pointer wrap is modulo DEPTH.
- stim_ready = (pending != DEPTH), registered-state based with no combinational path from res_valid. When full, a same-cycle pop does not enable a push.
- Pop: on res_valid && pending != 0, compare res_data with FIFO[rd_ptr] and increment rd_ptr.
  - Equal: pass_cnt++.
  - Unequal: fail_cnt++, mismatch = 1 the next cycle, err_sticky = 1.
- Compare latency: counters and pulses update at the clock edge that accepts res_valid; outputs are visible the following cycle.
- Unexpected result: res_valid with pending == 0 (judged on pre-edge state) → no pop, no counter change, unexpected = 1 the next cycle, err_sticky = 1. This holds even if a push occurs in the same cycle; there is no bypass.
- Simultaneous push and pop (not full, not empty): both occur and pending is unchanged.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- pending = push - pop accounting, registered.
- Reset mid-run: the queue is discarded and all statistics return to 0.
- State machine (2 states):
  - RUN: normal operation.
  - HALT: entered only with the optional feature.

Optional Feature:
- Macro: CHECK_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch or unexpected event moves the FSM RUN→HALT.
  - In HALT: stim_ready = 0, res_valid is ignored, counters and pending are frozen, and no further pulses are generated.
  - Only rst_n leaves HALT.
- Undefined: the FSM stays in RUN and checking continues after failures.

Test Plan:
- Reset, then push a=1001 b=0001 sel=00; return res=0001 → pass_cnt=1, fail_cnt=0, pending returns 0, err_sticky=0.
- Push all four ops with a=1001 b=0001 (expected 0001, 1001, 1000, 1110); return in order, with the third result corrupted to 0000 → pass_cnt=3, fail_cnt=1, one mismatch pulse, err_sticky=1.
- Push 4 vectors with no results → pending=4, stim_ready=0; a fifth stim_valid is not accepted. One pop then leads to stim_ready=1.
- res_valid=1 with an empty FIFO, in the same cycle as a push → unexpected pulse, counters unchanged, pending=1 afterwards.
- CNT_W=2, send 5 matching results → pass_cnt holds at 3.
- With CHECK_STOP_ON_FAIL_EN: a mismatch, then 2 further valid results → fail_cnt=1, pass_cnt unchanged, stim_ready=0. Asserting rst_n low mid-cycle clears everything asynchronously.
